// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: function codes and FSM states.
// Also holds the legality check used when decoding a command.
package alu_sequencer_pkg;

   localparam logic [3:0] FN_PASS_A  = 4'b0000;
   localparam logic [3:0] FN_INC     = 4'b0001;
   localparam logic [3:0] FN_ADD     = 4'b0010;
   localparam logic [3:0] FN_ADDC    = 4'b0011;
   localparam logic [3:0] FN_SUBB    = 4'b0100;
   localparam logic [3:0] FN_SUB     = 4'b0101;
   localparam logic [3:0] FN_DEC     = 4'b0110;
   localparam logic [3:0] FN_PASS_A2 = 4'b0111;
   localparam logic [3:0] FN_AND     = 4'b1000;
   localparam logic [3:0] FN_OR      = 4'b1001;
   localparam logic [3:0] FN_XOR     = 4'b1010;
   localparam logic [3:0] FN_NOT     = 4'b1011;
   localparam logic [3:0] FN_PASS_B  = 4'b1100;
   localparam logic [3:0] FUNC_MAX   = 4'b1100;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_DONE
   } state_t;

   function automatic logic func_legal(input logic [3:0] f);
      return f <= FUNC_MAX;
   endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// NREG x WIDTH register file: one synchronous write port,
// two combinational operand reads and a combinational debug read.
module alu_seq_regfile #(
   parameter int NREG  = 4,
   parameter int WIDTH = 16,
   localparam int IW   = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [IW-1:0]    wa,
   input  logic [WIDTH-1:0] wd,
   input  logic [IW-1:0]    ra_sel,
   output logic [WIDTH-1:0] ra_data,
   input  logic [IW-1:0]    rb_sel,
   output logic [WIDTH-1:0] rb_data,
   input  logic [IW-1:0]    dbg_sel,
   output logic [WIDTH-1:0] dbg_data
);

   logic [WIDTH-1:0] regs [NREG];

   always_ff @(posedge clk) begin
      if (rst) begin
         regs <= '{default: '0};
      end else if (we) begin
         regs[wa] <= wd;
      end
   end

   assign ra_data  = regs[ra_sel];
   assign rb_data  = regs[rb_sel];
   assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle controller that drives an external ALU over a small
// register file, with optional repeat loops feeding R[rd] back as A.
module alu_sequencer
   import alu_sequencer_pkg::*;
#(
   parameter int NREG  = 4,
   parameter int WIDTH = 16,
   localparam int IW   = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_load,
   input  logic [3:0]       cmd_func,
   input  logic [IW-1:0]    cmd_rd,
   input  logic [IW-1:0]    cmd_ra,
   input  logic [IW-1:0]    cmd_rb,
   input  logic [3:0]       cmd_rep,
   input  logic [WIDTH-1:0] cmd_imm,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_function_code,
   input  logic [WIDTH-1:0] alu_result,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] result_out,
   input  logic [IW-1:0]    dbg_sel,
   output logic [WIDTH-1:0] dbg_data
);

   state_t           state_q;
   state_t           state_d;
   logic [IW-1:0]    rd_q;
   logic [IW-1:0]    rb_q;
   logic [IW-1:0]    src_q;
   logic [3:0]       cnt_q;
   logic [3:0]       func_q;
   logic             err_q;

   logic             we;
   logic [IW-1:0]    wa;
   logic [WIDTH-1:0] wd;
   logic [WIDTH-1:0] rf_a;
   logic [WIDTH-1:0] rf_b;

   alu_seq_regfile #(
      .NREG  (NREG),
      .WIDTH (WIDTH)
   ) u_regfile (
      .clk      (clk),
      .rst      (rst),
      .we       (we),
      .wa       (wa),
      .wd       (wd),
      .ra_sel   (src_q),
      .ra_data  (rf_a),
      .rb_sel   (rb_q),
      .rb_data  (rf_b),
      .dbg_sel  (dbg_sel),
      .dbg_data (dbg_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d           = state_q;
      cmd_ready         = 1'b0;
      done              = 1'b0;
      err               = 1'b0;
      result_out        = '0;
      alu_a             = '0;
      alu_b             = '0;
      alu_function_code = '0;
      we                = 1'b0;
      wa                = rd_q;
      wd                = alu_result;
      unique case (state_q)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               if (cmd_load) begin
                  we      = 1'b1;
                  wa      = cmd_rd;
                  wd      = cmd_imm;
                  state_d = ST_DONE;
               end else if (!func_legal(cmd_func)) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_EXEC;
               end
            end
         end
         ST_EXEC: begin
            alu_a             = rf_a;
            alu_b             = rf_b;
            alu_function_code = func_q;
            we                = 1'b1;
            if (cnt_q == 4'd0) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            // src_q points at rd here, so port A yields the final R[rd]
            done       = 1'b1;
            err        = err_q;
            result_out = err_q ? '0 : rf_a;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q   <= '0;
         rb_q   <= '0;
         src_q  <= '0;
         cnt_q  <= '0;
         func_q <= '0;
         err_q  <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (cmd_valid) begin
                  rd_q   <= cmd_rd;
                  rb_q   <= cmd_rb;
                  func_q <= cmd_func;
                  cnt_q  <= cmd_rep;
                  src_q  <= cmd_load ? cmd_rd : cmd_ra;
                  err_q  <= !cmd_load && !func_legal(cmd_func);
               end
            end
            ST_EXEC: begin
               src_q <= rd_q;
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            ST_DONE: begin
               err_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed, table-driven bench for alu_sequencer with a behavioural ALU
// beside it, plus hand sequences for held-valid and reset-abort cases.
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_load;
   logic [3:0]  cmd_func;
   logic [1:0]  cmd_rd;
   logic [1:0]  cmd_ra;
   logic [1:0]  cmd_rb;
   logic [3:0]  cmd_rep;
   logic [15:0] cmd_imm;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [3:0]  alu_function_code;
   logic [15:0] alu_result;
   logic        done;
   logic        err;
   logic [15:0] result_out;
   logic [1:0]  dbg_sel;
   logic [15:0] dbg_data;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_sequencer dut (
      .clk               (clk),
      .rst               (rst),
      .cmd_valid         (cmd_valid),
      .cmd_ready         (cmd_ready),
      .cmd_load          (cmd_load),
      .cmd_func          (cmd_func),
      .cmd_rd            (cmd_rd),
      .cmd_ra            (cmd_ra),
      .cmd_rb            (cmd_rb),
      .cmd_rep           (cmd_rep),
      .cmd_imm           (cmd_imm),
      .alu_a             (alu_a),
      .alu_b             (alu_b),
      .alu_function_code (alu_function_code),
      .alu_result        (alu_result),
      .done              (done),
      .err               (err),
      .result_out        (result_out),
      .dbg_sel           (dbg_sel),
      .dbg_data          (dbg_data)
   );

   always_comb begin
      alu_result = '0;
      case (alu_function_code)
         4'h0: alu_result = alu_a;
         4'h1: alu_result = alu_a + 16'd1;
         4'h2: alu_result = alu_a + alu_b;
         4'h3: alu_result = alu_a + alu_b;
         4'h4: alu_result = alu_a - alu_b;
         4'h5: alu_result = alu_a - alu_b;
         4'h6: alu_result = alu_a - 16'd1;
         4'h7: alu_result = alu_a;
         4'h8: alu_result = alu_a & alu_b;
         4'h9: alu_result = alu_a | alu_b;
         4'hA: alu_result = alu_a ^ alu_b;
         4'hB: alu_result = ~alu_a;
         4'hC: alu_result = alu_b;
         default: alu_result = '0;
      endcase
   end

   typedef struct {
      logic        ld;
      logic [3:0]  fn;
      logic [1:0]  rd;
      logic [1:0]  ra;
      logic [1:0]  rb;
      logic [3:0]  rep;
      logic [15:0] imm;
      logic        e_err;
      logic [15:0] e_res;
      int          e_lat;
      logic [1:0]  c_reg;
      logic [15:0] c_val;
   } vec_t;

   vec_t tv [14];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int lat;
      cmd_load  = v.ld;
      cmd_func  = v.fn;
      cmd_rd    = v.rd;
      cmd_ra    = v.ra;
      cmd_rb    = v.rb;
      cmd_rep   = v.rep;
      cmd_imm   = v.imm;
      cmd_valid = 1'b1;
      chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
      step();
      cmd_valid = 1'b0;
      lat = 1;
      while (!done && lat < 40) begin
         step();
         lat++;
      end
      if (!done) begin
         chk({tag, "_timeout"}, 32'(lat), 32'(v.e_lat));
      end else begin
         chk({tag, "_lat"}, 32'(lat), 32'(v.e_lat));
         chk({tag, "_err"}, 32'(err), 32'(v.e_err));
         chk({tag, "_res"}, 32'(result_out), 32'(v.e_res));
      end
      step();
      dbg_sel = v.c_reg;
      #1;
      chk({tag, "_dbg"}, 32'(dbg_data), 32'(v.c_val));
   endtask

   initial begin
      int    pulses;
      vec_t  post;
      logic  busy;
      logic [15:0] exp_a [10];

      //        ld  fn    rd ra rb rep imm       err res      lat creg cval
      tv[0]  = '{1, 4'h0, 1, 0, 0, 0, 16'h0005, 0, 16'h0005, 1,  1, 16'h0005};
      tv[1]  = '{1, 4'h0, 2, 0, 0, 0, 16'h0003, 0, 16'h0003, 1,  2, 16'h0003};
      tv[2]  = '{0, 4'h2, 0, 1, 2, 0, 16'h0000, 0, 16'h0008, 2,  0, 16'h0008};
      tv[3]  = '{1, 4'h0, 0, 0, 0, 0, 16'h0007, 0, 16'h0007, 1,  0, 16'h0007};
      tv[4]  = '{0, 4'h1, 0, 0, 0, 9, 16'h0000, 0, 16'h0011, 11, 0, 16'h0011};
      tv[5]  = '{1, 4'h0, 1, 0, 0, 0, 16'hFFFF, 0, 16'hFFFF, 1,  1, 16'hFFFF};
      tv[6]  = '{0, 4'h1, 1, 1, 0, 0, 16'h0000, 0, 16'h0000, 2,  1, 16'h0000};
      tv[7]  = '{0, 4'hD, 0, 1, 2, 3, 16'h0000, 1, 16'h0000, 1,  0, 16'h0011};
      tv[8]  = '{0, 4'h2, 3, 2, 2, 2, 16'h0000, 0, 16'h000C, 4,  3, 16'h000C};
      tv[9]  = '{0, 4'h2, 2, 0, 2, 1, 16'h0000, 0, 16'h0028, 3,  2, 16'h0028};
      tv[10] = '{0, 4'hA, 0, 0, 3, 0, 16'h0000, 0, 16'h001D, 2,  0, 16'h001D};
      tv[11] = '{0, 4'hC, 1, 0, 3, 0, 16'h0000, 0, 16'h000C, 2,  1, 16'h000C};
      tv[12] = '{0, 4'hF, 3, 0, 0, 0, 16'h0000, 1, 16'h0000, 1,  3, 16'h000C};
      tv[13] = '{1, 4'hF, 2, 0, 0, 0, 16'hBEEF, 0, 16'hBEEF, 1,  2, 16'hBEEF};

      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_load  = 1'b0;
      cmd_func  = '0;
      cmd_rd    = '0;
      cmd_ra    = '0;
      cmd_rb    = '0;
      cmd_rep   = '0;
      cmd_imm   = '0;
      dbg_sel   = '0;
      step();
      step();
      rst = 1'b0;
      step();
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_res", 32'(result_out), 32'd0);
      chk("rst_fc", 32'(alu_function_code), 32'd0);
      for (int r = 0; r < 4; r++) begin
         dbg_sel = 2'(r);
         #1;
         chk($sformatf("rst_r%0d", r), 32'(dbg_data), 32'd0);
      end

      for (int i = 0; i < 14; i++) begin
         run_vec(tv[i], $sformatf("v%0d", i));
      end

      // R0=1D R1=C R2=BEEF R3=C; hold valid through two INC rep=2 runs
      exp_a = '{16'h0, 16'h000C, 16'h000D, 16'h000E, 16'h0,
                16'h0, 16'h000F, 16'h0010, 16'h0011, 16'h0};
      cmd_load  = 1'b0;
      cmd_func  = 4'h1;
      cmd_rd    = 2'd1;
      cmd_ra    = 2'd1;
      cmd_rb    = 2'd0;
      cmd_rep   = 4'd2;
      cmd_valid = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         step();
         if (c == 6) cmd_valid = 1'b0;
         busy = (c >= 1 && c <= 3) || (c >= 6 && c <= 8);
         chk($sformatf("hold_c%0d_done", c), 32'(done),
             32'((c == 4) || (c == 9)));
         chk($sformatf("hold_c%0d_ready", c), 32'(cmd_ready),
             32'(c == 5));
         chk($sformatf("hold_c%0d_fc", c), 32'(alu_function_code),
             busy ? 32'd1 : 32'd0);
         chk($sformatf("hold_c%0d_a", c), 32'(alu_a), 32'(exp_a[c]));
         if (c == 4) chk("hold_res1", 32'(result_out), 32'h000F);
         if (c == 9) chk("hold_res2", 32'(result_out), 32'h0012);
      end
      step();

      // reset in the middle of a rep=5 loop
      cmd_func  = 4'h1;
      cmd_rd    = 2'd2;
      cmd_ra    = 2'd2;
      cmd_rep   = 4'd5;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      step();
      chk("abort_busy", 32'(cmd_ready), 32'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_ready", 32'(cmd_ready), 32'd1);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_fc", 32'(alu_function_code), 32'd0);
      for (int r = 0; r < 4; r++) begin
         dbg_sel = 2'(r);
         #1;
         chk($sformatf("abort_r%0d", r), 32'(dbg_data), 32'd0);
      end
      pulses = 0;
      for (int c = 0; c < 8; c++) begin
         step();
         if (done) pulses++;
      end
      chk("abort_pulses", 32'(pulses), 32'd0);

      post = '{1, 4'h0, 3, 0, 0, 0, 16'h1234, 0, 16'h1234, 1, 3, 16'h1234};
      run_vec(post, "post");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
